// File: rtl/io_shift_unit.sv
// Multi-word I/O shifter: a DEPTH-word push window returning any XLEN-bit slice,
// shifted left/right and optionally bit-reversed, through a registered read port.
module io_shift_unit #(
   parameter  int XLEN   = 8,
   parameter  int DEPTH  = 2,
   localparam int AMT_W  = $clog2(XLEN*(DEPTH-1)+1),
   localparam int FILL_W = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [XLEN-1:0]   wr_data,
   input  logic              flush,
   input  logic              cfg_wr,
   input  logic [AMT_W-1:0]  cfg_amount,
   input  logic              cfg_dir,
   input  logic              cfg_rev,
   input  logic              rd_req,
   output logic [XLEN-1:0]   rd_data,
   output logic              rd_valid,
   output logic [FILL_W-1:0] fill,
   output logic              full
);

   localparam int WW    = XLEN*DEPTH;
   localparam int MAX_A = XLEN*(DEPTH-1);

   logic [WW-1:0]     win;
   logic [WW-1:0]     push_base;
   logic [AMT_W-1:0]  amount;
   logic              dir;
   logic              rev;
   logic [AMT_W-1:0]  eff_amt;
   logic [WW-1:0]     shl;
   logic [WW-1:0]     shr;
   logic [XLEN-1:0]   slice;
   logic [XLEN-1:0]   result;

   // Stored amount is kept unclamped; saturation happens only on use.
   always_comb begin
      eff_amt = (amount > AMT_W'(MAX_A)) ? AMT_W'(MAX_A) : amount;
      shl     = win << eff_amt;
      shr     = win >> eff_amt;
      slice   = dir ? shr[XLEN-1:0] : shl[WW-1 -: XLEN];
      result  = slice;
      if (rev) begin
         for (int unsigned i = 0; i < XLEN; i++) begin
            result[i] = slice[XLEN-1-i];
         end
      end
   end

   // A flush in the same cycle as a push clears the window before the push lands.
   assign push_base = flush ? '0 : win;

   always_ff @(posedge clk) begin
      if (rst) begin
         win      <= '0;
         amount   <= '0;
         dir      <= 1'b0;
         rev      <= 1'b0;
         fill     <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            rd_data <= result;
         end

         if (wr_en) begin
            win <= {wr_data, push_base[WW-1:XLEN]};
         end else if (flush) begin
            win <= '0;
         end

         if (flush) begin
            fill <= wr_en ? FILL_W'(1) : '0;
         end else if (wr_en && (fill != FILL_W'(DEPTH))) begin
            fill <= fill + 1'b1;
         end

         if (cfg_wr) begin
            amount <= cfg_amount;
            dir    <= cfg_dir;
            rev    <= cfg_rev;
         end
      end
   end

   assign full = (fill == FILL_W'(DEPTH));

endmodule

// File: tb/tb_io_shift_unit.sv
// Drives four shifter geometries with identical stimulus and checks them against
// an arithmetic model of the window/slice rules plus hand-derived directed vectors.
module tb_io_shift_unit;

   localparam int unsigned XL[4] = '{8, 8, 8, 16};
   localparam int unsigned DP[4] = '{2, 3, 4, 3};
   localparam int unsigned AW[4] = '{4, 5, 5, 6};

   logic        clk = 1'b0;
   logic        rst, wr_en, flush, cfg_wr, cfg_dir, cfg_rev, rd_req;
   logic [15:0] wr_data;
   logic [5:0]  cfg_amount;

   logic [7:0]  rdd0, rdd1, rdd2;
   logic [15:0] rdd3;
   logic        rdv0, rdv1, rdv2, rdv3;
   logic [1:0]  f0, f1, f3;
   logic [2:0]  f2;
   logic        fu0, fu1, fu2, fu3;

   logic [15:0] obs_d[4];
   logic        obs_v[4];
   logic [2:0]  obs_f[4];
   logic        obs_full[4];

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   logic [63:0] m_win[4];
   int unsigned m_amt[4];
   int unsigned m_fill[4];
   logic        m_dir[4];
   logic        m_rev[4];
   logic        m_v[4];
   logic [15:0] m_d[4];

   always #5 clk = ~clk;

   io_shift_unit #(.XLEN(8), .DEPTH(2)) u_8x2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data[7:0]), .flush(flush),
      .cfg_wr(cfg_wr), .cfg_amount(cfg_amount[3:0]), .cfg_dir(cfg_dir), .cfg_rev(cfg_rev),
      .rd_req(rd_req), .rd_data(rdd0), .rd_valid(rdv0), .fill(f0), .full(fu0));
   io_shift_unit #(.XLEN(8), .DEPTH(3)) u_8x3 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data[7:0]), .flush(flush),
      .cfg_wr(cfg_wr), .cfg_amount(cfg_amount[4:0]), .cfg_dir(cfg_dir), .cfg_rev(cfg_rev),
      .rd_req(rd_req), .rd_data(rdd1), .rd_valid(rdv1), .fill(f1), .full(fu1));
   io_shift_unit #(.XLEN(8), .DEPTH(4)) u_8x4 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data[7:0]), .flush(flush),
      .cfg_wr(cfg_wr), .cfg_amount(cfg_amount[4:0]), .cfg_dir(cfg_dir), .cfg_rev(cfg_rev),
      .rd_req(rd_req), .rd_data(rdd2), .rd_valid(rdv2), .fill(f2), .full(fu2));
   io_shift_unit #(.XLEN(16), .DEPTH(3)) u_16x3 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
      .cfg_wr(cfg_wr), .cfg_amount(cfg_amount), .cfg_dir(cfg_dir), .cfg_rev(cfg_rev),
      .rd_req(rd_req), .rd_data(rdd3), .rd_valid(rdv3), .fill(f3), .full(fu3));

   assign obs_d[0] = {8'h00, rdd0};
   assign obs_d[1] = {8'h00, rdd1};
   assign obs_d[2] = {8'h00, rdd2};
   assign obs_d[3] = rdd3;
   assign obs_v[0] = rdv0;
   assign obs_v[1] = rdv1;
   assign obs_v[2] = rdv2;
   assign obs_v[3] = rdv3;
   assign obs_f[0] = {1'b0, f0};
   assign obs_f[1] = {1'b0, f1};
   assign obs_f[2] = f2;
   assign obs_f[3] = {1'b0, f3};
   assign obs_full[0] = fu0;
   assign obs_full[1] = fu1;
   assign obs_full[2] = fu2;
   assign obs_full[3] = fu3;

   function automatic logic [15:0] model_result(int k);
      int unsigned x, d, ww, a;
      logic [63:0] wmask, xmask, t, r;
      x = XL[k];
      d = DP[k];
      ww = x*d;
      a = m_amt[k];
      if (a > x*(d-1)) a = x*(d-1);
      wmask = (64'd1 << ww) - 64'd1;
      xmask = (64'd1 << x) - 64'd1;
      if (!m_dir[k]) t = (((m_win[k] << a) & wmask) >> (ww - x)) & xmask;
      else           t = (m_win[k] >> a) & xmask;
      if (m_rev[k]) begin
         r = '0;
         for (int unsigned i = 0; i < x; i++) r[x-1-i] = t[i];
         t = r;
      end
      return t[15:0];
   endfunction

   task automatic model_step();
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            m_win[k] = '0; m_amt[k] = 0; m_fill[k] = 0;
            m_dir[k] = 1'b0; m_rev[k] = 1'b0; m_v[k] = 1'b0; m_d[k] = '0;
         end else begin
            m_v[k] = rd_req;
            if (rd_req) m_d[k] = model_result(k);
            if (flush) begin
               m_win[k] = '0;
               m_fill[k] = 0;
            end
            if (wr_en) begin
               m_win[k] = ((64'(wr_data) & ((64'd1 << XL[k]) - 64'd1)) << (XL[k]*(DP[k]-1)))
                          | (m_win[k] >> XL[k]);
               m_fill[k] = (m_fill[k] < DP[k]) ? m_fill[k] + 1 : DP[k];
            end
            if (cfg_wr) begin
               m_amt[k] = 32'(cfg_amount) & ((32'd1 << AW[k]) - 1);
               m_dir[k] = cfg_dir;
               m_rev[k] = cfg_rev;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      wr_en = 1'b1; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_cfg(input logic [5:0] a, input logic dr, input logic rv);
      cfg_wr = 1'b1; cfg_amount = a; cfg_dir = dr; cfg_rev = rv;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic do_read();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (obs_v[k] !== 1'b0 || obs_d[k] !== 16'h0 || obs_f[k] !== 3'd0 || obs_full[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset[%0d]: got v=%b d=%h fill=%0d full=%b, expected all zero",
                     k, obs_v[k], obs_d[k], obs_f[k], obs_full[k]);
         end
      end
      do_read();
      vectors++;
      if (obs_v[0] !== 1'b1 || obs_d[0] !== 16'h00) begin
         miscompares++;
         $display("FAIL reset_read: got v=%b d=%h, expected v=1 d=00", obs_v[0], obs_d[0]);
      end
   endtask

   task automatic test_modes_8x2();
      logic [5:0]  t_amt[6] = '{6'd3, 6'd3, 6'd3, 6'd0, 6'd8, 6'd15};
      logic        t_dir[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        t_rev[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [15:0] t_exp[6] = '{16'h6D, 16'hB5, 16'hB6, 16'hCD, 16'hAB, 16'hAB};
      push(16'hAB);
      push(16'hCD);
      vectors++;
      if (obs_f[0] !== 3'd2 || obs_full[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_8x2: got fill=%0d full=%b, expected fill=2 full=1", obs_f[0], obs_full[0]);
      end
      for (int i = 0; i < 6; i++) begin
         do_cfg(t_amt[i], t_dir[i], t_rev[i]);
         do_read();
         vectors++;
         if (obs_v[0] !== 1'b1 || obs_d[0] !== t_exp[i]) begin
            miscompares++;
            $display("FAIL mode_8x2[%0d]: got v=%b d=%h, expected v=1 d=%h", i, obs_v[0], obs_d[0], t_exp[i]);
         end
      end
   endtask

   task automatic test_depth3();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      push(16'h11);
      push(16'h22);
      push(16'h33);
      do_cfg(6'd12, 1'b0, 1'b0);
      do_read();
      vectors++;
      if (obs_d[1] !== 16'h21) begin
         miscompares++;
         $display("FAIL d3_left: got %h expected 21", obs_d[1]);
      end
      do_cfg(6'd12, 1'b1, 1'b0);
      do_read();
      vectors++;
      if (obs_d[1] !== 16'h32) begin
         miscompares++;
         $display("FAIL d3_right: got %h expected 32", obs_d[1]);
      end
      push(16'h44);
      vectors++;
      if (obs_f[1] !== 3'd3 || obs_full[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL d3_fill_sat: got fill=%0d full=%b, expected fill=3 full=1", obs_f[1], obs_full[1]);
      end
      do_cfg(6'd0, 1'b0, 1'b0);
      do_read();
      vectors++;
      if (obs_d[1] !== 16'h44) begin
         miscompares++;
         $display("FAIL d3_newest: got %h expected 44", obs_d[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] held;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      push(16'hAB);
      push(16'hCD);
      do_cfg(6'd0, 1'b0, 1'b0);
      rd_req = 1'b1; wr_en = 1'b1; wr_data = 16'hEE;
      tick();
      wr_en = 1'b0;
      vectors++;
      if (obs_v[0] !== 1'b1 || obs_d[0] !== 16'hCD) begin
         miscompares++;
         $display("FAIL hazard_pre_push: got v=%b d=%h, expected v=1 d=cd", obs_v[0], obs_d[0]);
      end
      tick();
      vectors++;
      if (obs_v[0] !== 1'b1 || obs_d[0] !== 16'hEE) begin
         miscompares++;
         $display("FAIL b2b_second: got v=%b d=%h, expected v=1 d=ee", obs_v[0], obs_d[0]);
      end
      held = obs_d[0];
      rd_req = 1'b0;
      tick();
      vectors++;
      if (obs_v[0] !== 1'b0 || obs_d[0] !== 16'hEE) begin
         miscompares++;
         $display("FAIL hold: got v=%b d=%h, expected v=0 d=%h", obs_v[0], obs_d[0], held);
      end
      flush = 1'b1; wr_en = 1'b1; wr_data = 16'h5A;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      vectors++;
      if (obs_f[0] !== 3'd1 || obs_full[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_push_fill: got fill=%0d full=%b, expected fill=1 full=0", obs_f[0], obs_full[0]);
      end
      do_read();
      vectors++;
      if (obs_d[0] !== 16'h5A) begin
         miscompares++;
         $display("FAIL flush_push_hi: got %h expected 5a", obs_d[0]);
      end
      do_cfg(6'd0, 1'b1, 1'b0);
      do_read();
      vectors++;
      if (obs_d[0] !== 16'h00) begin
         miscompares++;
         $display("FAIL flush_push_lo: got %h expected 00", obs_d[0]);
      end
   endtask

   task automatic test_reset_midstream();
      push(16'h77);
      do_cfg(6'd5, 1'b1, 1'b1);
      rst = 1'b1; rd_req = 1'b1;
      tick();
      rst = 1'b0; rd_req = 1'b0;
      vectors++;
      if (obs_v[0] !== 1'b0 || obs_d[0] !== 16'h00 || obs_f[0] !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_mid: got v=%b d=%h fill=%0d, expected v=0 d=00 fill=0", obs_v[0], obs_d[0], obs_f[0]);
      end
      do_read();
      vectors++;
      if (obs_v[0] !== 1'b1 || obs_d[0] !== 16'h00) begin
         miscompares++;
         $display("FAIL rst_mid_read: got v=%b d=%h, expected v=1 d=00", obs_v[0], obs_d[0]);
      end
      push(16'hAB);
      push(16'hCD);
      do_read();
      vectors++;
      if (obs_d[0] !== 16'hCD) begin
         miscompares++;
         $display("FAIL rst_cfg_default: got %h expected cd", obs_d[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 10000; n++) begin
         rst        = ($urandom_range(0, 299) == 0);
         flush      = ($urandom_range(0, 15) == 0);
         wr_en      = $urandom_range(0, 1) == 1;
         cfg_wr     = ($urandom_range(0, 3) == 0);
         rd_req     = $urandom_range(0, 1) == 1;
         wr_data    = 16'($urandom);
         cfg_amount = 6'($urandom);
         cfg_dir    = $urandom_range(0, 1) == 1;
         cfg_rev    = $urandom_range(0, 1) == 1;
         tick();
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (obs_v[k] !== m_v[k] || obs_d[k] !== m_d[k] || obs_f[k] !== 3'(m_fill[k])
                || obs_full[k] !== (m_fill[k] == DP[k])) begin
               miscompares++;
               $display("FAIL random[%0d] cyc %0d: got v=%b d=%h fill=%0d full=%b, expected v=%b d=%h fill=%0d full=%b",
                        k, n, obs_v[k], obs_d[k], obs_f[k], obs_full[k],
                        m_v[k], m_d[k], m_fill[k], (m_fill[k] == DP[k]));
            end
         end
      end
      rst = 1'b0; flush = 1'b0; wr_en = 1'b0; cfg_wr = 1'b0; rd_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; flush = 1'b0; cfg_wr = 1'b0; rd_req = 1'b0;
      cfg_dir = 1'b0; cfg_rev = 1'b0; wr_data = '0; cfg_amount = '0;
      #1;
      test_reset();
      test_modes_8x2();
      test_depth3();
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
